rename_regfile: RTL and testbench

Parametrised architectural register file with a rename (ROB-tag) table, N read ports, same-cycle commit bypass, and a FIFO of rename-table checkpoints for single-cycle branch recovery. It sits between the decoder (reads operands, claims rd), the ROB (commits values, allocates and releases branch checkpoints) and the misbranch logic (restores a checkpoint or flushes everything). It supersedes the flat regFile, whose only recovery mode was a full flush.

---
 rtl/rename_regfile_pkg.sv | 19 +
 rtl/rename_regfile_ckpt_fifo_ctrl.sv | 66 ++++++
 rtl/rename_regfile.sv | 158 +++++++++++++++
 tb/tb_rename_regfile.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/rename_regfile_pkg.sv
//==============================================================================
// rename_regfile_pkg - shared rename constants and entry type.  rev 1.0
//==============================================================================
`default_nettype none

package rename_regfile_pkg;

  localparam int ZERO_ROB    = 0;
  localparam int ZERO_REG    = 0;
  localparam int ENTRY_TAG_W = 4;

  typedef struct packed {
    logic [ENTRY_TAG_W-1:0] tag;
    logic                   busy;
  } rename_entry_t;

endpackage

`default_nettype wire

// File: rtl/rename_regfile_ckpt_fifo_ctrl.sv
//==============================================================================
// ckpt_fifo_ctrl - head/tail/count pointers for the rename checkpoint FIFO.  rev 1.0
//==============================================================================
`default_nettype none

module ckpt_fifo_ctrl #(
  parameter int NUM_CKPT = 4,
  parameter int CKPT_W   = $clog2(NUM_CKPT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              flush,
  input  logic              take,
  input  logic              rel,
  input  logic              restore,
  input  logic [CKPT_W-1:0] restore_id,
  output logic              take_fire,
  output logic [CKPT_W-1:0] head,
  output logic [CKPT_W-1:0] tail,
  output logic [CKPT_W:0]   count,
  output logic              full
);

  localparam logic [CKPT_W:0]   CNT_ONE = 1;
  localparam logic [CKPT_W-1:0] PTR_ONE = 1;
  localparam logic [CKPT_W:0]   CNT_MAX = NUM_CKPT;

  logic              rel_fire;
  logic              restore_fire;
  logic [CKPT_W-1:0] restore_off;
  logic [CKPT_W:0]   restore_count;

  assign full          = (count == CNT_MAX);
  assign rel_fire      = ena && rel && (count != '0);
  assign restore_fire  = ena && restore;
  // A full FIFO still accepts a take when the oldest slot is freed this cycle.
  assign take_fire     = ena && take && !restore && !flush && (!full || rel_fire);
  assign restore_off   = restore_id - head;
  assign restore_count = {1'b0, restore_off} + CNT_ONE;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (restore_fire) begin
      tail  <= restore_id + PTR_ONE;
      count <= restore_count;
    end else begin
      if (take_fire) tail <= tail + PTR_ONE;
      if (rel_fire)  head <= head + PTR_ONE;
      if (take_fire && !rel_fire)      count <= count + CNT_ONE;
      else if (rel_fire && !take_fire) count <= count - CNT_ONE;
    end
  end

  a_release_nonempty : assert property (@(posedge clk) disable iff (rst)
    (ena && rel && !flush && !restore) |-> (count != '0));

  a_restore_valid : assert property (@(posedge clk) disable iff (rst)
    (ena && restore && !flush) |-> ({1'b0, restore_off} < count));

endmodule

`default_nettype wire

// File: rtl/rename_regfile.sv
//==============================================================================
// rename_regfile - register file with ROB-tag rename table and checkpoints.  rev 1.0
//==============================================================================
`default_nettype none

module rename_regfile
  import rename_regfile_pkg::*;
#(
  parameter int REG_NUM  = 32,
  parameter int DATA_W   = 32,
  parameter int ROB_W    = 4,
  parameter int NUM_READ = 2,
  parameter int NUM_CKPT = 4,
  parameter int REG_W    = $clog2(REG_NUM),
  parameter int CKPT_W   = $clog2(NUM_CKPT)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ena,
  input  logic [NUM_READ*REG_W-1:0]    rd_idx,
  output logic [NUM_READ*DATA_W-1:0]   rd_value,
  output logic [NUM_READ*ROB_W-1:0]    rd_tag,
  output logic [NUM_READ-1:0]          rd_busy,
  input  logic                         in_assign_ena,
  input  logic [REG_W-1:0]             in_assign_reg,
  input  logic [ROB_W-1:0]             in_assign_tag,
  input  logic                         in_commit_ena,
  input  logic [REG_W-1:0]             in_commit_reg,
  input  logic [ROB_W-1:0]             in_commit_tag,
  input  logic [DATA_W-1:0]            in_commit_value,
  input  logic                         in_ckpt_take,
  output logic [CKPT_W-1:0]            out_ckpt_id,
  output logic                         out_ckpt_full,
  input  logic                         in_ckpt_release,
  input  logic                         in_ckpt_restore,
  input  logic [CKPT_W-1:0]            in_ckpt_restore_id,
  input  logic                         in_flush
);

  localparam logic [ROB_W-1:0] TAG_NONE = ROB_W'(ZERO_ROB);
  localparam logic [REG_W-1:0] REG_ZERO = REG_W'(ZERO_REG);

  logic [DATA_W-1:0]  datas       [REG_NUM];
  logic [ROB_W-1:0]   tags        [REG_NUM];
  logic [REG_NUM-1:0] busy;
  logic [ROB_W-1:0]   snap_tag    [NUM_CKPT][REG_NUM];
  logic [REG_NUM-1:0] snap_busy   [NUM_CKPT];

  logic [ROB_W-1:0]   live_tag_n  [REG_NUM];
  logic [REG_NUM-1:0] live_busy_n;
  logic [ROB_W-1:0]   snap_tag_n  [NUM_CKPT][REG_NUM];
  logic [REG_NUM-1:0] snap_busy_n [NUM_CKPT];

  logic               commit_ok;
  logic               take_fire;
  logic [CKPT_W-1:0]  head;
  logic [CKPT_W-1:0]  tail;
  logic [CKPT_W:0]    count;

  ckpt_fifo_ctrl #(
    .NUM_CKPT (NUM_CKPT),
    .CKPT_W   (CKPT_W)
  ) u_ckpt (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .flush      (in_flush),
    .take       (in_ckpt_take),
    .rel        (in_ckpt_release),
    .restore    (in_ckpt_restore),
    .restore_id (in_ckpt_restore_id),
    .take_fire  (take_fire),
    .head       (head),
    .tail       (tail),
    .count      (count),
    .full       (out_ckpt_full)
  );

  assign out_ckpt_id = tail;
  assign commit_ok   = in_commit_ena && (in_commit_reg != REG_ZERO);

  // Assign is applied after the commit clear so it wins on the same register.
  always_comb begin
    live_busy_n = busy;
    for (int r = 0; r < REG_NUM; r++) begin
      live_tag_n[r] = tags[r];
      if (commit_ok && in_commit_reg == REG_W'(r) && tags[r] == in_commit_tag) begin
        live_tag_n[r]  = TAG_NONE;
        live_busy_n[r] = 1'b0;
      end
      if (in_assign_ena && r != 0 && in_assign_reg == REG_W'(r)) begin
        live_tag_n[r]  = in_assign_tag;
        live_busy_n[r] = 1'b1;
      end
    end
  end

  always_comb begin
    for (int c = 0; c < NUM_CKPT; c++) begin
      snap_busy_n[c] = snap_busy[c];
      for (int r = 0; r < REG_NUM; r++) begin
        snap_tag_n[c][r] = snap_tag[c][r];
        if (commit_ok && in_commit_reg == REG_W'(r) && snap_tag[c][r] == in_commit_tag) begin
          snap_tag_n[c][r]  = TAG_NONE;
          snap_busy_n[c][r] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
      for (int r = 0; r < REG_NUM; r++) begin
        datas[r] <= '0;
        tags[r]  <= '0;
      end
      for (int c = 0; c < NUM_CKPT; c++) begin
        snap_busy[c] <= '0;
        for (int r = 0; r < REG_NUM; r++) snap_tag[c][r] <= '0;
      end
    end else if (in_flush) begin
      busy <= '0;
      for (int r = 0; r < REG_NUM; r++) tags[r] <= '0;
    end else if (ena) begin
      if (commit_ok) datas[in_commit_reg] <= in_commit_value;
      for (int c = 0; c < NUM_CKPT; c++) begin
        snap_busy[c] <= snap_busy_n[c];
        for (int r = 0; r < REG_NUM; r++) snap_tag[c][r] <= snap_tag_n[c][r];
      end
      if (in_ckpt_restore) begin
        busy <= snap_busy_n[in_ckpt_restore_id];
        for (int r = 0; r < REG_NUM; r++) tags[r] <= snap_tag_n[in_ckpt_restore_id][r];
      end else begin
        busy <= live_busy_n;
        for (int r = 0; r < REG_NUM; r++) tags[r] <= live_tag_n[r];
        if (take_fire) begin
          snap_busy[tail] <= live_busy_n;
          for (int r = 0; r < REG_NUM; r++) snap_tag[tail][r] <= live_tag_n[r];
        end
      end
    end
  end

  for (genvar i = 0; i < NUM_READ; i++) begin : g_read
    logic [REG_W-1:0] idx;
    logic             hit;
    assign idx = rd_idx[i*REG_W +: REG_W];
    assign hit = in_commit_ena && (idx == in_commit_reg) && (tags[idx] == in_commit_tag)
                 && (idx != REG_ZERO);
    assign rd_value[i*DATA_W +: DATA_W] = hit ? in_commit_value : datas[idx];
    assign rd_tag[i*ROB_W +: ROB_W]     = hit ? TAG_NONE : tags[idx];
    assign rd_busy[i]                   = hit ? 1'b0 : busy[idx];
  end

endmodule

`default_nettype wire

// File: tb/tb_rename_regfile.sv
//==============================================================================
// tb_rename_regfile - directed self-checking bench for rename_regfile.  rev 1.0
//==============================================================================
`default_nettype none

module tb_rename_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        ena;
  logic [9:0]  rd_idx;
  logic [63:0] rd_value;
  logic [7:0]  rd_tag;
  logic [1:0]  rd_busy;
  logic        in_assign_ena;
  logic [4:0]  in_assign_reg;
  logic [3:0]  in_assign_tag;
  logic        in_commit_ena;
  logic [4:0]  in_commit_reg;
  logic [3:0]  in_commit_tag;
  logic [31:0] in_commit_value;
  logic        in_ckpt_take;
  logic [1:0]  out_ckpt_id;
  logic        out_ckpt_full;
  logic        in_ckpt_release;
  logic        in_ckpt_restore;
  logic [1:0]  in_ckpt_restore_id;
  logic        in_flush;

  int checks   = 0;
  int failures = 0;

  rename_regfile dut (
    .clk                (clk),
    .rst                (rst),
    .ena                (ena),
    .rd_idx             (rd_idx),
    .rd_value           (rd_value),
    .rd_tag             (rd_tag),
    .rd_busy            (rd_busy),
    .in_assign_ena      (in_assign_ena),
    .in_assign_reg      (in_assign_reg),
    .in_assign_tag      (in_assign_tag),
    .in_commit_ena      (in_commit_ena),
    .in_commit_reg      (in_commit_reg),
    .in_commit_tag      (in_commit_tag),
    .in_commit_value    (in_commit_value),
    .in_ckpt_take       (in_ckpt_take),
    .out_ckpt_id        (out_ckpt_id),
    .out_ckpt_full      (out_ckpt_full),
    .in_ckpt_release    (in_ckpt_release),
    .in_ckpt_restore    (in_ckpt_restore),
    .in_ckpt_restore_id (in_ckpt_restore_id),
    .in_flush           (in_flush)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  task automatic idle();
    in_assign_ena = 0; in_assign_reg = 0; in_assign_tag = 0;
    in_commit_ena = 0; in_commit_reg = 0; in_commit_tag = 0; in_commit_value = 0;
    in_ckpt_take = 0; in_ckpt_release = 0; in_ckpt_restore = 0;
    in_ckpt_restore_id = 0; in_flush = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] a, input logic [4:0] b);
    rd_idx = {b, a};
    #1;
  endtask

  task automatic assign_reg(input logic [4:0] r, input logic [3:0] t);
    in_assign_ena = 1; in_assign_reg = r; in_assign_tag = t;
  endtask

  task automatic commit(input logic [4:0] r, input logic [3:0] t, input logic [31:0] v);
    in_commit_ena = 1; in_commit_reg = r; in_commit_tag = t; in_commit_value = v;
  endtask

  initial begin
    idle();
    rst = 1; ena = 1; rd_idx = '0;
    repeat (2) @(posedge clk);
    #1 rst = 0;

    // Reset state
    rd(5, 0);
    chk("rst_x5_value", rd_value[31:0], 0);
    chk("rst_x5_busy", {31'b0, rd_busy[0]}, 0);
    chk("rst_x0_value", rd_value[63:32], 0);
    chk("rst_x0_tag", {28'b0, rd_tag[7:4]}, 0);
    chk("rst_x0_busy", {31'b0, rd_busy[1]}, 0);
    chk("rst_full", {31'b0, out_ckpt_full}, 0);
    chk("rst_id", {30'b0, out_ckpt_id}, 0);

    // Assign then commit with same-cycle bypass
    assign_reg(3, 2); step(); idle();
    rd(3, 0);
    chk("asg_x3_busy", {31'b0, rd_busy[0]}, 1);
    chk("asg_x3_tag", {28'b0, rd_tag[3:0]}, 2);
    commit(3, 2, 32'hDEAD); rd(3, 0);
    chk("byp_x3_value", rd_value[31:0], 32'hDEAD);
    chk("byp_x3_busy", {31'b0, rd_busy[0]}, 0);
    chk("byp_x3_tag", {28'b0, rd_tag[3:0]}, 0);
    step(); idle(); rd(3, 0);
    chk("cmt_x3_value", rd_value[31:0], 32'hDEAD);
    chk("cmt_x3_busy", {31'b0, rd_busy[0]}, 0);

    // Stale-tag commit writes data but leaves the claim in place
    assign_reg(3, 2); step(); idle();
    commit(3, 7, 32'hBEEF); rd(3, 0);
    chk("stale_nobyp_value", rd_value[31:0], 32'hDEAD);
    step(); idle(); rd(3, 0);
    chk("stale_x3_value", rd_value[31:0], 32'hBEEF);
    chk("stale_x3_busy", {31'b0, rd_busy[0]}, 1);
    chk("stale_x3_tag", {28'b0, rd_tag[3:0]}, 2);
    commit(3, 2, 32'h1234); step(); idle();

    // Register 0 ignores writes and never bypasses
    assign_reg(0, 5); commit(0, 0, 32'hFF); rd(0, 0);
    chk("x0_nobyp_value", rd_value[31:0], 0);
    step(); idle(); rd(0, 0);
    chk("x0_value", rd_value[31:0], 0);
    chk("x0_busy", {31'b0, rd_busy[0]}, 0);
    chk("x0_tag", {28'b0, rd_tag[3:0]}, 0);

    // Assign beats a same-register commit clear
    assign_reg(5, 6); step(); idle();
    assign_reg(5, 8); commit(5, 6, 32'h55); step(); idle(); rd(5, 0);
    chk("prec_x5_tag", {28'b0, rd_tag[3:0]}, 8);
    chk("prec_x5_busy", {31'b0, rd_busy[0]}, 1);
    chk("prec_x5_value", rd_value[31:0], 32'h55);

    // Take, rename again, restore
    assign_reg(4, 1); step(); idle();
    chk("take0_id", {30'b0, out_ckpt_id}, 0);
    in_ckpt_take = 1; step(); idle();
    assign_reg(4, 3); step(); idle(); rd(4, 0);
    chk("rn_x4_tag", {28'b0, rd_tag[3:0]}, 3);
    in_ckpt_restore = 1; in_ckpt_restore_id = 0; step(); idle(); rd(4, 0);
    chk("rest0_x4_tag", {28'b0, rd_tag[3:0]}, 1);
    chk("rest0_x4_busy", {31'b0, rd_busy[0]}, 1);
    chk("rest0_id", {30'b0, out_ckpt_id}, 1);

    // Commit after take must not be resurrected by restore
    assign_reg(6, 5); in_ckpt_take = 1;
    chk("take1_id", {30'b0, out_ckpt_id}, 1);
    step(); idle();
    commit(6, 5, 32'h66); step(); idle();
    assign_reg(6, 9); step(); idle(); rd(6, 4);
    chk("rn_x6_tag", {28'b0, rd_tag[3:0]}, 9);
    in_ckpt_restore = 1; in_ckpt_restore_id = 1; step(); idle(); rd(6, 4);
    chk("rest1_x6_busy", {31'b0, rd_busy[0]}, 0);
    chk("rest1_x6_tag", {28'b0, rd_tag[3:0]}, 0);
    chk("rest1_x6_value", rd_value[31:0], 32'h66);
    chk("rest1_x4_tag", {28'b0, rd_tag[7:4]}, 1);
    chk("rest1_x4_busy", {31'b0, rd_busy[1]}, 1);
    chk("rest1_id", {30'b0, out_ckpt_id}, 2);

    // Fill to full, overflow take dropped, release+take while full
    in_ckpt_take = 1; step();
    chk("fill3_full", {31'b0, out_ckpt_full}, 0);
    step();
    chk("fill4_full", {31'b0, out_ckpt_full}, 1);
    chk("fill4_id", {30'b0, out_ckpt_id}, 0);
    step(); idle();
    chk("ovf_full", {31'b0, out_ckpt_full}, 1);
    chk("ovf_id", {30'b0, out_ckpt_id}, 0);
    in_ckpt_take = 1; in_ckpt_release = 1; #1;
    chk("reltake_id", {30'b0, out_ckpt_id}, 0);
    step(); idle();
    chk("reltake_full", {31'b0, out_ckpt_full}, 1);
    chk("reltake_next_id", {30'b0, out_ckpt_id}, 1);
    in_ckpt_release = 1; step(); idle();
    chk("rel_full", {31'b0, out_ckpt_full}, 0);

    // Flush beats a simultaneous restore with 3 checkpoints live
    assign_reg(7, 4); step(); idle();
    in_flush = 1; in_ckpt_restore = 1; in_ckpt_restore_id = 2; step(); idle(); rd(7, 4);
    chk("flush_x7_busy", {31'b0, rd_busy[0]}, 0);
    chk("flush_x7_tag", {28'b0, rd_tag[3:0]}, 0);
    chk("flush_x4_busy", {31'b0, rd_busy[1]}, 0);
    chk("flush_id", {30'b0, out_ckpt_id}, 0);
    chk("flush_full", {31'b0, out_ckpt_full}, 0);
    rd(3, 0);
    chk("flush_x3_value", rd_value[31:0], 32'h1234);

    // ena low blocks normal updates
    ena = 0; assign_reg(8, 3); step(); idle(); ena = 1; rd(8, 0);
    chk("noena_x8_busy", {31'b0, rd_busy[0]}, 0);

    // Empty after flush: exactly four takes to full
    for (int i = 0; i < 4; i++) begin
      in_ckpt_take = 1; step();
      chk("refill_full", {31'b0, out_ckpt_full}, (i == 3) ? 32'd1 : 32'd0);
    end
    idle(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
